hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Pipeline sequencing controller for the five-stage processor.
- Drives the PC write enable, the fetch/decode register's write enable and flush, and the decode/execute bubble insert.
- Resolves load-use hazards, taken-branch flushes, memory-busy freezes and the multi-cycle interrupt-entry sequence.
- Sits beside the decode stage; it sees decode source registers and execute-stage status.

Parameters:
- REG_W, 3, register-index width (8 GPRs).
- INT_CYCLES, 3, cycles in the interrupt-entry sequence (legal range 2..4).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_src1  in  REG_W  decode-stage source register 1.
- id_src2  in  REG_W  decode-stage source register 2.
- id_src1_used  in  1  source 1 is read by the decode instruction.
- id_src2_used  in  1  source 2 is read by the decode instruction.
- ex_mem_read  in  1  execute-stage instruction is a load.
- ex_rd  in  REG_W  execute-stage destination register.
- ex_branch_taken  in  1  execute-stage branch/jump resolved taken.
- mem_busy  in  1  memory stage not ready; whole pipe must freeze.
- int_req  in  1  level interrupt request, held by the source until int_ack.
- pc_write_en  out  1  1 = PC updates this cycle.
- fd_write_en  out  1  active-low: 0 = F/D register loads, 1 = holds.
- fd_flush  out  1  1 = F/D register loads NOP instead of fetched word.
- de_bubble  out  1  1 = D/E register loads a bubble (control zeroed).
- int_active  out  1  interrupt-entry sequence in progress.
- int_step  out  2  current interrupt-entry step, 0..INT_CYCLES-1.
- int_ack  out  1  one-cycle pulse on the final interrupt-entry step.

Behaviour:
- States: RUN, MEM_WAIT, INT_SEQ. The state register and step counter are asynchronously cleared by reset=0.
- While reset=0:
  - state=RUN, step=0.
  - pc_write_en=0, fd_write_en=1, fd_flush=1, de_bubble=1.
  - int_active=0, int_ack=0, int_step=0.
- All outputs are combinational from state, step and inputs. No added latency.
- Load-use hazard (luh) = ex_mem_read & ((id_src1_used & ex_rd==id_src1) | (id_src2_used & ex_rd==id_src2)).
- Priority each cycle: mem_busy > ex_branch_taken > luh > int_req.
- RUN:
  - mem_busy=1: freeze. pc_write_en=0, fd_write_en=1, fd_flush=0, de_bubble=0. Next state MEM_WAIT.
  - Else ex_branch_taken=1: pc_write_en=1, fd_write_en=0, fd_flush=1, de_bubble=1. Stay RUN.
  - Else luh=1: pc_write_en=0, fd_write_en=1, fd_flush=0, de_bubble=1. Stay RUN. The stall is exactly one cycle, because the bubble removes the load from EX.
  - Else int_req=1: this cycle is normal flow (pc_write_en=1, fd_write_en=0, fd_flush=0, de_bubble=0). Next state INT_SEQ, step=0.
  - Else normal flow, same outputs as above.
- MEM_WAIT:
  - Freeze outputs as in RUN while mem_busy=1.
  - On mem_busy=0, the same cycle is evaluated with RUN rules. Next state follows the RUN rules.
  - ex_branch_taken and int_req are ignored while frozen, since the instruction stays in EX.
- INT_SEQ:
  - int_active=1, int_step=step.
  - fd_write_en=0, fd_flush=1, de_bubble=1 every step.
  - pc_write_en=0 except at step=INT_CYCLES-1, where pc_write_en=1 (vector load) and int_ack=1.
  - step increments each cycle. After the last step, the next state is RUN and step=0.
  - mem_busy=1 during INT_SEQ: full freeze (pc_write_en=0, fd_write_en=1, fd_flush=0, de_bubble=0, int_ack=0). Step holds; state stays INT_SEQ.
  - ex_branch_taken and int_req are ignored inside INT_SEQ.
- int_req still high in the cycle after int_ack: a new sequence starts, as for any RUN-cycle request.
- Reset asserted mid-sequence: immediate return to RUN with step=0. No int_ack is issued.
- Index compare uses full REG_W bits. Register 0 is not special.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then release with all inputs 0 → during reset pc_write_en=0, fd_write_en=1, fd_flush=1, de_bubble=1. After release: pc_write_en=1, fd_write_en=0, fd_flush=0, de_bubble=0.
- Load-use: ex_mem_read=1, ex_rd=3, id_src2=3, id_src2_used=1 for one cycle → that cycle pc_write_en=0, fd_write_en=1, de_bubble=1. Next cycle with ex_mem_read=0 → normal flow. Repeat with id_src2_used=0 → no stall.
- Branch plus load-use in the same cycle: ex_branch_taken=1 with the hazard from the previous scenario → pc_write_en=1, fd_flush=1, de_bubble=1, fd_write_en=0.
- Memory wait: mem_busy=1 for 4 cycles with ex_branch_taken=1 → 4 freeze cycles (pc_write_en=0, fd_write_en=1, fd_flush=0). Cycle 5 with mem_busy=0 → branch flush outputs.
- Interrupt: int_req=1 in RUN, INT_CYCLES=3 → int_step 0,1,2. pc_write_en=0,0,1. int_ack only at step 2. fd_flush=1 throughout. Back to RUN afterwards.
- Interrupt with interruptions:
  - mem_busy=1 for 2 cycles at step 1 → step holds at 1 through the freeze, then 2 with int_ack.
  - Separately, reset=0 at step 1 → immediate RUN, int_ack never pulses.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch flushes, memory-busy
// freezes and the multi-cycle interrupt-entry sequence for the five-stage core.
module hazard_stall_ctrl #(
    parameter int REG_W      = 3,
    parameter int INT_CYCLES = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_src1_used,
    input  logic             id_src2_used,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    input  logic             int_req,
    output logic             pc_write_en,
    output logic             fd_write_en,
    output logic             fd_flush,
    output logic             de_bubble,
    output logic             int_active,
    output logic [1:0]       int_step,
    output logic             int_ack
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        INT_SEQ  = 2'd2
    } state_t;

    localparam logic [1:0] LAST_STEP = 2'(INT_CYCLES - 1);

    state_t     state_r;
    state_t     state_next_s;
    logic [1:0] step_r;
    logic [1:0] step_next_s;
    logic       luh_s;

    // Load-use hazard detection against the load currently in EX.
    always_comb begin
        luh_s = ex_mem_read &
                ((id_src1_used & (ex_rd == id_src1)) |
                 (id_src2_used & (ex_rd == id_src2)));
    end

    // Output decode and next-state selection; MEM_WAIT shares the RUN rules
    // because a released freeze is evaluated exactly like a RUN cycle.
    always_comb begin
        pc_write_en  = 1'b1;
        fd_write_en  = 1'b0;
        fd_flush     = 1'b0;
        de_bubble    = 1'b0;
        int_active   = 1'b0;
        int_step     = 2'd0;
        int_ack      = 1'b0;
        state_next_s = state_r;
        step_next_s  = step_r;
        if (!reset) begin
            pc_write_en  = 1'b0;
            fd_write_en  = 1'b1;
            fd_flush     = 1'b1;
            de_bubble    = 1'b1;
            state_next_s = RUN;
            step_next_s  = 2'd0;
        end else begin
            case (state_r)
                RUN, MEM_WAIT: begin
                    step_next_s = 2'd0;
                    if (mem_busy) begin
                        pc_write_en  = 1'b0;
                        fd_write_en  = 1'b1;
                        state_next_s = MEM_WAIT;
                    end else if (ex_branch_taken) begin
                        fd_flush     = 1'b1;
                        de_bubble    = 1'b1;
                        state_next_s = RUN;
                    end else if (luh_s) begin
                        pc_write_en  = 1'b0;
                        fd_write_en  = 1'b1;
                        de_bubble    = 1'b1;
                        state_next_s = RUN;
                    end else if (int_req) begin
                        state_next_s = INT_SEQ;
                    end else begin
                        state_next_s = RUN;
                    end
                end
                INT_SEQ: begin
                    int_active = 1'b1;
                    int_step   = step_r;
                    if (mem_busy) begin
                        pc_write_en = 1'b0;
                        fd_write_en = 1'b1;
                    end else begin
                        fd_flush  = 1'b1;
                        de_bubble = 1'b1;
                        if (step_r == LAST_STEP) begin
                            pc_write_en  = 1'b1;
                            int_ack      = 1'b1;
                            state_next_s = RUN;
                            step_next_s  = 2'd0;
                        end else begin
                            pc_write_en = 1'b0;
                            step_next_s = step_r + 2'd1;
                        end
                    end
                end
                default: begin
                    pc_write_en  = 1'b0;
                    fd_write_en  = 1'b1;
                    fd_flush     = 1'b1;
                    de_bubble    = 1'b1;
                    state_next_s = RUN;
                    step_next_s  = 2'd0;
                end
            endcase
        end
    end

    // State and step registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= RUN;
            step_r  <= 2'd0;
        end else begin
            state_r <= state_next_s;
            step_r  <= step_next_s;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed, table-driven bench for hazard_stall_ctrl (REG_W=3, INT_CYCLES=3).
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] id_src1, id_src2, ex_rd;
    logic       id_src1_used, id_src2_used, ex_mem_read;
    logic       ex_branch_taken, mem_busy, int_req;
    logic       pc_write_en, fd_write_en, fd_flush, de_bubble;
    logic       int_active, int_ack;
    logic [1:0] int_step;

    int errors = 0;
    int checks = 0;

    // Expected output vector: {pc_write_en, fd_write_en, fd_flush, de_bubble,
    // int_active, int_step[1:0], int_ack}
    localparam logic [7:0] E_NORM  = 8'b1000_0000;
    localparam logic [7:0] E_STALL = 8'b0101_0000;
    localparam logic [7:0] E_FLUSH = 8'b1011_0000;
    localparam logic [7:0] E_FRZ   = 8'b0100_0000;
    localparam logic [7:0] E_RST   = 8'b0111_0000;
    localparam logic [7:0] E_INT0  = 8'b0011_1000;
    localparam logic [7:0] E_INT1  = 8'b0011_1010;
    localparam logic [7:0] E_INT2  = 8'b1011_1101;
    localparam logic [7:0] E_FRZ1  = 8'b0100_1010;

    typedef struct {
        string      name;
        logic       rst;
        logic       mb;
        logic       br;
        logic       ir;
        logic       mr;
        logic [2:0] rd;
        logic [2:0] s1;
        logic       u1;
        logic [2:0] s2;
        logic       u2;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[$];

    hazard_stall_ctrl #(.REG_W(3), .INT_CYCLES(3)) dut (
        .clk(clk), .reset(reset),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_src1_used(id_src1_used), .id_src2_used(id_src2_used),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy), .int_req(int_req),
        .pc_write_en(pc_write_en), .fd_write_en(fd_write_en),
        .fd_flush(fd_flush), .de_bubble(de_bubble),
        .int_active(int_active), .int_step(int_step), .int_ack(int_ack)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(string n, logic rst, logic mb, logic br, logic ir,
                                logic mr, logic [2:0] rd, logic [2:0] s1, logic u1,
                                logic [2:0] s2, logic u2, logic [7:0] e);
        vec_t v;
        v.name = n; v.rst = rst; v.mb = mb; v.br = br; v.ir = ir; v.mr = mr;
        v.rd = rd; v.s1 = s1; v.u1 = u1; v.s2 = s2; v.u2 = u2; v.exp = e;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        reset = v.rst; mem_busy = v.mb; ex_branch_taken = v.br; int_req = v.ir;
        ex_mem_read = v.mr; ex_rd = v.rd; id_src1 = v.s1; id_src1_used = v.u1;
        id_src2 = v.s2; id_src2_used = v.u2;
    endtask

    task automatic check(input string n, input logic [7:0] e);
        logic [7:0] act;
        act = {pc_write_en, fd_write_en, fd_flush, de_bubble,
               int_active, int_step, int_ack};
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s: got %b expected %b (pc fdw flush bubble act step ack)",
                     n, act, e);
        end
    endtask

    // Drive on the falling edge, compare mid-low-phase, state advances on the rising edge.
    task automatic apply(input vec_t v);
        @(negedge clk);
        drive(v);
        #2;
        check(v.name, v.exp);
    endtask

    initial begin
        drive(mk("init", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, E_RST));

        // Hand sequence: reset held two cycles, then released with idle inputs.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #2;
            check($sformatf("reset_hold_%0d", i), E_RST);
        end
        apply(mk("reset_release", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, E_NORM));

        //          name               rst   mb    br    ir    mr    rd    s1    u1    s2    u2    exp
        tbl.push_back(mk("idle",        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, E_NORM));
        tbl.push_back(mk("luh_src2",    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 3'd0, 1'b0, 3'd3, 1'b1, E_STALL));
        tbl.push_back(mk("after_luh",   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 3'd0, 1'b0, 3'd3, 1'b1, E_NORM));
        tbl.push_back(mk("src2_unused", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 3'd0, 1'b0, 3'd3, 1'b0, E_NORM));
        tbl.push_back(mk("msb_differs", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 3'd7, 1'b1, 3'd0, 1'b0, E_NORM));
        tbl.push_back(mk("luh_reg0",    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 1'b1, 3'd5, 1'b0, E_STALL));
        tbl.push_back(mk("br_plus_luh", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 3'd0, 1'b0, 3'd3, 1'b1, E_FLUSH));
        tbl.push_back(mk("mb_br_1",     1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, E_FRZ));
        tbl.push_back(mk("mb_br_2",     1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, E_FRZ));
        tbl.push_back(mk("mb_br_3",     1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, E_FRZ));
        tbl.push_back(mk("mb_br_4",     1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, E_FRZ));
        tbl.push_back(mk("mb_release",  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, E_FLUSH));
        tbl.push_back(mk("mb_over_luh", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 3'd2, 1'b1, 3'd0, 1'b0, E_FRZ));
        tbl.push_back(mk("release_luh", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 3'd2, 1'b1, 3'd0, 1'b0, E_STALL));
        tbl.push_back(mk("int_req",     1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, E_NORM));
        tbl.push_back(mk("int_s0_br",   1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, E_INT0));
        tbl.push_back(mk("int_s1",      1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, E_INT1));
        tbl.push_back(mk("int_s2_ack",  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, E_INT2));
        tbl.push_back(mk("int_done",    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, E_NORM));
        tbl.push_back(mk("int2_req",    1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, E_NORM));
        tbl.push_back(mk("int2_s0",     1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, E_INT0));
        tbl.push_back(mk("int2_frz_a",  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, E_FRZ1));
        tbl.push_back(mk("int2_frz_b",  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, E_FRZ1));
        tbl.push_back(mk("int2_s1",     1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, E_INT1));
        tbl.push_back(mk("int2_s2_ack", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, E_INT2));
        tbl.push_back(mk("req_held",    1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, E_NORM));
        tbl.push_back(mk("int3_s0",     1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, E_INT0));
        tbl.push_back(mk("int3_s1",     1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, E_INT1));
        tbl.push_back(mk("int3_s2_ack", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, E_INT2));
        tbl.push_back(mk("int3_done",   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, E_NORM));

        foreach (tbl[i]) apply(tbl[i]);

        // Hand sequence: reset asserted at step 1; no ack may appear afterwards.
        apply(mk("rs_req",  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, E_NORM));
        apply(mk("rs_s0",   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, E_INT0));
        @(negedge clk);
        #2;
        check("rs_s1", E_INT1);
        reset = 1'b0;
        #1;
        check("rs_mid_reset", E_RST);
        int_req = 1'b0;
        begin
            int acks;
            acks = 0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                reset = (i >= 1);
                #2;
                if (int_ack === 1'b1) acks++;
            end
            checks++;
            if (acks != 0) begin
                errors++;
                $display("FAIL rs_no_ack: got %0d ack pulses expected 0", acks);
            end
        end
        check("rs_back_run", E_NORM);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
